// File: rtl/less_than.sv
// Two's-complement / unsigned magnitude comparator built on a single subtraction.
// Provides a combinational signed less-than and a registered, valid-qualified lt/eq/gt set.
module less_than #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] InA,
    input  logic [WIDTH-1:0] InB,
    input  logic             in_valid,
    input  logic             signed_mode,
    output logic             Out,
    output logic             out_valid,
    output logic             lt_q,
    output logic             eq_q,
    output logic             gt_q
);

    logic [WIDTH:0] diff;
    logic           carry;
    logic           neg;
    logic           zero;
    logic           ovf;
    logic           slt;
    logic           ult;
    logic           lt_sel;

    logic           out_valid_d;
    logic           lt_d;
    logic           eq_d;
    logic           gt_d;

    // A - B as A + ~B + 1, one bit wider so the top bit is the carry (no borrow).
    always_comb begin
        diff  = {1'b0, InA} + {1'b0, ~InB} + (WIDTH+1)'(1);
        carry = diff[WIDTH];
        neg   = diff[WIDTH-1];
        zero  = (diff[WIDTH-1:0] == '0);
        ovf   = (InA[WIDTH-1] != InB[WIDTH-1]) && (diff[WIDTH-1] != InA[WIDTH-1]);
        slt   = neg ^ ovf;
        ult   = ~carry;
    end

    assign Out = slt;

    always_comb begin
        out_valid_d = in_valid;
        lt_d        = lt_q;
        eq_d        = eq_q;
        gt_d        = gt_q;
        lt_sel      = signed_mode ? slt : ult;
        if (in_valid) begin
            lt_d = lt_sel;
            eq_d = zero;
            gt_d = ~lt_sel & ~zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            lt_q      <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
        end else begin
            out_valid <= out_valid_d;
            lt_q      <= lt_d;
            eq_q      <= eq_d;
            gt_q      <= gt_d;
        end
    end

endmodule

// File: tb/tb_less_than.sv
// Directed and randomized self-checking bench for less_than (WIDTH = 16).
// Expected values are hand-computed or come from native signed/unsigned compares.
module tb_less_than;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] InA;
    logic [WIDTH-1:0] InB;
    logic             in_valid;
    logic             signed_mode;
    logic             Out;
    logic             out_valid;
    logic             lt_q;
    logic             eq_q;
    logic             gt_q;

    int unsigned checks;
    int unsigned errors;

    less_than #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .InA        (InA),
        .InB        (InB),
        .in_valid   (in_valid),
        .signed_mode(signed_mode),
        .Out        (Out),
        .out_valid  (out_valid),
        .lt_q       (lt_q),
        .eq_q       (eq_q),
        .gt_q       (gt_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic comb(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic exp);
        InA = a;
        InB = b;
        #1;
        check($sformatf("out %h/%h", a, b), 32'(Out), 32'(exp));
    endtask

    // {out_valid, lt, eq, gt} one cycle after presenting a valid pair
    task automatic cap(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic m,
                       input logic [3:0] exp, input string tag);
        InA         = a;
        InB         = b;
        signed_mode = m;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        check(tag, 32'({out_valid, lt_q, eq_q, gt_q}), 32'(exp));
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rm;
        logic             elt;
        logic             eeq;

        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        signed_mode = 1'b0;
        InA         = '0;
        InB         = '0;
        #1;
        check("reset regs", 32'({out_valid, lt_q, eq_q, gt_q}), 32'h0);

        // Combinational path works while in reset
        comb(16'h0001, 16'h0002, 1'b1);
        comb(16'h0005, 16'h0003, 1'b0);
        comb(16'h000A, 16'h000A, 1'b0);
        comb(16'hFFFE, 16'hFFFF, 1'b1);
        comb(16'hFFFD, 16'hFFFC, 1'b0);
        comb(16'h0000, 16'h0000, 1'b0);
        comb(16'h7FFF, 16'h7FFE, 1'b0);
        comb(16'h8000, 16'h7FFF, 1'b1);
        comb(16'h7FFF, 16'h8000, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        cap(16'h8000, 16'h7FFF, 1'b1, 4'b1100, "signed min vs max");
        cap(16'h8000, 16'h7FFF, 1'b0, 4'b1001, "unsigned min vs max");
        cap(16'hFFFF, 16'hFFFF, 1'b1, 4'b1010, "eq FFFF signed");
        cap(16'hFFFF, 16'hFFFF, 1'b0, 4'b1010, "eq FFFF unsigned");
        cap(16'h0000, 16'h0000, 1'b0, 4'b1010, "eq 0000 unsigned");

        // Back-to-back stream
        cap(16'h0001, 16'h0002, 1'b1, 4'b1100, "stream 0");
        cap(16'h0002, 16'h0001, 1'b1, 4'b1001, "stream 1");
        cap(16'h0003, 16'h0003, 1'b1, 4'b1010, "stream 2");
        cap(16'hFFFF, 16'h0000, 1'b1, 4'b1100, "stream 3");
        in_valid = 1'b0;
        InA      = 16'h0005;
        InB      = 16'h0001;
        @(posedge clk);
        #1;
        check("stream idle hold", 32'({out_valid, lt_q, eq_q, gt_q}), 32'b0100);
        @(posedge clk);
        #1;
        check("stream idle hold 2", 32'({out_valid, lt_q, eq_q, gt_q}), 32'b0100);

        // Asynchronous reset between edges while a result is valid
        cap(16'h0009, 16'h0004, 1'b0, 4'b1001, "pre-reset");
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset", 32'({out_valid, lt_q, eq_q, gt_q}), 32'h0);
        comb(16'hFFF0, 16'h0010, 1'b1);
        comb(16'h0010, 16'hFFF0, 1'b0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("held in reset", 32'({out_valid, lt_q, eq_q, gt_q}), 32'h0);
        #2;
        rst_n = 1'b1;
        cap(16'h0010, 16'hFFF0, 1'b0, 4'b1100, "first after reset");

        // Random pairs against native compares, with one-hot checks
        for (int i = 0; i < 10000; i++) begin
            ra = WIDTH'($urandom);
            rb = (i % 8 == 0) ? ra : WIDTH'($urandom);
            rm = 1'($urandom);
            elt = rm ? ($signed(ra) < $signed(rb)) : (ra < rb);
            eeq = (ra == rb);
            InA = ra;
            InB = rb;
            #1;
            check("rand out", 32'(Out), 32'($signed(ra) < $signed(rb)));
            cap(ra, rb, rm, {1'b1, elt, eeq, ~elt & ~eeq}, "rand reg");
            check("rand onehot", 32'($onehot({lt_q, eq_q, gt_q})), 32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
